full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Registered, parameterizable-width binary adder used as the arithmetic element of a CGRA tile.
- Adds operands a and b plus an optional incoming carry, gated by carry_listen.
- Produces a registered sum, a carry-out and an ack flag one clock after the inputs are sampled.
- An enable input, on_off, powers the adder down to a cleared output state.

Parameters:
- width, 16, operand and sum width in bits; legal range ≥ 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- a  input  width  operand A.
- b  input  width  operand B.
- carry_in  input  1  incoming carry from the neighbouring tile.
- carry_listen  input  1  1 = include carry_in in the sum; 0 = ignore carry_in.
- on_off  input  1  1 = adder active; 0 = adder disabled, outputs cleared.
- c  output  width  registered sum, low width bits.
- carry_out  output  1  registered carry, bit width of the full sum.
- ack  output  1  registered result-valid flag.

Behaviour:
- All outputs come from flops. There is no combinational path from inputs to outputs.
- Reset is asynchronous and active-low. While reset = 0: c = 0, carry_out = 0, ack = 0, taking effect immediately and independent of clk.
- Releasing reset is synchronous in effect: the first capture happens on the first rising edge with reset = 1.
- Each rising edge with reset = 1 and on_off = 1:
  - cin_eff = carry_in AND carry_listen.
  - sum[width:0] = zero-extended a + zero-extended b + cin_eff, computed at width+1 bits.
  - c <= sum[width-1:0]; carry_out <= sum[width]; ack <= 1.
- Each rising edge with reset = 1 and on_off = 0: c <= 0, carry_out <= 0, ack <= 0. The operands are not evaluated.
- Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is one result per cycle. There is no backpressure, and ack has no handshake partner.
- ack stays high on every cycle that on_off is sampled high. It falls one cycle after on_off is sampled low.
- When carry_listen = 0, carry_in is a don't-care, including X.
- Wrap-around: an all-ones operand plus 1 gives c = 0 and carry_out = 1. The maximum sum, all-ones + all-ones + 1, gives c = all-ones and carry_out = 1.
- Reset asserted mid-operation clears the outputs immediately. No partial result persists.
- Returning on_off from 0 to 1 needs no warm-up: the first active edge produces a valid result.

Optional Feature:
- Macro: FULL_ADDER_OVF_EN.
- Defined:
  - Adds output port overflow (1 bit), registered alongside c.
  - overflow <= (a[width-1] == b[width-1]) AND (c_next[width-1] != a[width-1]), i.e. two's-complement signed overflow of the same sum, including cin_eff.
  - overflow resets to 0 and is cleared when on_off = 0.
- Undefined:
  - The overflow port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Assert reset = 0 with on_off = 1 and toggling clk -> c = 0x0000, carry_out = 0, ack = 0 immediately, independent of clk.
- a = 0x000A, b = 0x0005, carry_in = 0, carry_listen = 0, on_off = 1 -> after one edge: c = 0x000F, carry_out = 0, ack = 1.
- Same operands, carry_in = 1, carry_listen = 0 -> c = 0x000F, carry_out = 0, ack = 1 (carry ignored).
- a = 0xFFFF, b = 0x0001, carry_listen = 0 -> c = 0x0000, carry_out = 1. Then a = 0xFFFF, b = 0x0000, carry_in = 1, carry_listen = 1 -> c = 0x0000, carry_out = 1, ack = 1.
- a = 0x000A, b = 0x0005, carry_in = 1, carry_listen = 1, on_off = 0 -> after one edge: c = 0x0000, carry_out = 0, ack = 0. Then on_off = 1 -> after one edge: c = 0x0010, carry_out = 0, ack = 1.
- FULL_ADDER_OVF_EN defined: a = 0x7FFF, b = 0x0001, carry_listen = 0 -> c = 0x8000, carry_out = 0, overflow = 1. Then a = 0x8000, b = 0x8000 -> c = 0x0000, carry_out = 1, overflow = 1.

Source files
------------

// File: rtl/full_adder.sv
// Registered width-bit adder with gated carry-in; optional signed overflow output when FULL_ADDER_OVF_EN is defined.
// Latency 1 cycle, one result per cycle, no backpressure (ack is a plain valid flag).
module full_adder #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             carry_in,
  input  logic             carry_listen,
  input  logic             on_off,
  output logic [width-1:0] c,
  output logic             carry_out,
  output logic             ack
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  logic [width-1:0] c_d, c_q;
  logic             carry_out_d, carry_out_q;
  logic             ack_d, ack_q;
  logic             cin_eff;
  logic [width:0]   sum;

  always_comb begin
    cin_eff     = carry_in & carry_listen;
    sum         = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, cin_eff};
    c_d         = '0;
    carry_out_d = 1'b0;
    ack_d       = 1'b0;
    // A disabled adder drives cleared outputs regardless of the operands.
    if (on_off) begin
      c_d         = sum[width-1:0];
      carry_out_d = sum[width];
      ack_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q         <= '0;
      carry_out_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      c_q         <= c_d;
      carry_out_q <= carry_out_d;
      ack_q       <= ack_d;
    end
  end

  assign c         = c_q;
  assign carry_out = carry_out_q;
  assign ack       = ack_q;

`ifdef FULL_ADDER_OVF_EN
  logic overflow_d, overflow_q;

  // Signed overflow: like-signed operands producing a result of the opposite sign.
  always_comb begin
    overflow_d = 1'b0;
    if (on_off) begin
      overflow_d = (a[width-1] == b[width-1]) && (sum[width-1] != a[width-1]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed-vector bench for full_adder (width 16), including async reset and on_off corner cases.
module tb_full_adder;

  logic        clk;
  logic        reset;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic        carry_listen;
  logic        on_off;
  logic [15:0] c;
  logic        carry_out;
  logic        ack;
`ifdef FULL_ADDER_OVF_EN
  logic        overflow;
`endif

  int checks   = 0;
  int failures = 0;

  full_adder #(.width(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .a            (a),
    .b            (b),
    .carry_in     (carry_in),
    .carry_listen (carry_listen),
    .on_off       (on_off),
    .c            (c),
    .carry_out    (carry_out),
    .ack          (ack)
`ifdef FULL_ADDER_OVF_EN
    ,
    .overflow     (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        cl;
    logic        on;
    logic [15:0] exp_c;
    logic        exp_co;
    logic        exp_ack;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string name, input logic [15:0] ec, input logic eco,
                               input logic eack, input logic eovf);
    check({name, ".c"}, {16'h0, c}, {16'h0, ec});
    check({name, ".carry_out"}, {31'h0, carry_out}, {31'h0, eco});
    check({name, ".ack"}, {31'h0, ack}, {31'h0, eack});
`ifdef FULL_ADDER_OVF_EN
    check({name, ".overflow"}, {31'h0, overflow}, {31'h0, eovf});
`else
    if (eovf === 1'bx) $display("unexpected x in overflow column");
`endif
  endtask

  task automatic drive(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                       input logic tcl, input logic ton);
    a            = ta;
    b            = tb_;
    carry_in     = tcin;
    carry_listen = tcl;
    on_off       = ton;
  endtask

  initial begin
    //           a        b        cin   cl    on    c        co    ack   ovf
    vecs[0]  = '{16'h000A, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{16'h000A, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{16'h000A, 16'h0005, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{16'h000A, 16'h0005, 1'b1, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{16'h1234, 16'h4321, 1'b0, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{16'hABCD, 16'h1234, 1'b1, 1'b1, 1'b1, 16'hBE02, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

    // Reset asserted from time zero with the adder enabled and the clock running.
    reset = 1'b0;
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    #1;
    check_outputs("reset_t1", 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset_clocked", 16'h0000, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check_outputs("reset_release_no_edge", 16'h0000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].cl, vecs[i].on);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_c, vecs[i].exp_co,
                    vecs[i].exp_ack, vecs[i].exp_ovf);
    end

    // Outputs must not follow inputs between edges.
    @(negedge clk);
    drive(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_outputs("reg_load", 16'h3333, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(16'h0F00, 16'h00F0, 1'b0, 1'b0, 1'b1);
    #1;
    check_outputs("no_comb_path", 16'h3333, 1'b0, 1'b1, 1'b0);

    // ack stays high while enabled, drops one edge after on_off goes low.
    @(posedge clk);
    #1;
    check_outputs("ack_hold", 16'h0FF0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    on_off = 1'b0;
    #1;
    check_outputs("ack_before_edge", 16'h0FF0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("ack_fall", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Mid-operation reset clears outputs immediately, between clock edges.
    @(negedge clk);
    drive(16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_outputs("pre_midreset", 16'h0001, 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_outputs("midreset_async", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("midreset_held", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_reset_first", 16'h0001, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
